// File: rtl/mem_noc_buf.sv
// mem_noc_buf: credit-gated request/response buffer between a master and a memory-side slave.
// Optional macro MEM_NOC_BYPASS_EN adds zero-latency pass-through on both paths.
package mem_noc_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;
endpackage

module mem_noc_buf
    import mem_noc_pkg::*;
#(
    parameter int REQ_DP  = 4,
    parameter int RESP_DP = 4,
    parameter int CNT_W   = $clog2(RESP_DP) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             src_req_valid,
    output logic             src_req_ready,
    input  mem_req_t         src_req,
    output logic             src_resp_valid,
    input  logic             src_resp_ready,
    output mem_resp_t        src_resp,
    output logic             dest_req_valid,
    input  logic             dest_req_ready,
    output mem_req_t         dest_req,
    input  logic             dest_resp_valid,
    output logic             dest_resp_ready,
    input  mem_resp_t        dest_resp,
    output logic [CNT_W-1:0] outstanding,
    output logic             resp_err
);
    // Handshake: a transfer happens on a rising clk edge when valid && ready;
    // no valid output is derived from the matching ready input.
    localparam int RQ_AW = $clog2(REQ_DP);
    localparam int RS_AW = $clog2(RESP_DP);

    mem_req_t        req_mem [REQ_DP];
    logic [RQ_AW:0]  req_wptr, req_rptr;
    logic            req_full, req_empty, req_push, req_pop;

    mem_resp_t       resp_mem [RESP_DP];
    logic [RS_AW:0]  resp_wptr, resp_rptr, resp_occ;
    logic            resp_empty, resp_push, resp_pop;

    logic credit_ok, src_req_fire, dest_req_fire, src_resp_fire;
    logic unexpected, resp_accept;

    assign req_empty = (req_wptr == req_rptr);
    assign req_full  = (req_wptr[RQ_AW-1:0] == req_rptr[RQ_AW-1:0]) &&
                       (req_wptr[RQ_AW] != req_rptr[RQ_AW]);
    assign resp_empty = (resp_wptr == resp_rptr);
    assign resp_occ   = resp_wptr - resp_rptr;

    // A request may only leave if a response slot is still free for it.
    assign credit_ok     = (outstanding < CNT_W'(RESP_DP));
    assign src_req_ready = ~req_full;
    assign src_req_fire  = src_req_valid && src_req_ready;
    assign dest_req_fire = dest_req_valid && dest_req_ready;
    assign src_resp_fire = src_resp_valid && src_resp_ready;

    // Every queued or in-flight response already has a request behind it;
    // a response arriving beyond that count has no owner.
    assign dest_resp_ready = 1'b1;
    assign unexpected      = dest_resp_valid && (CNT_W'(resp_occ) == outstanding);
    assign resp_accept     = dest_resp_valid && !unexpected;

`ifdef MEM_NOC_BYPASS_EN
    assign dest_req_valid = credit_ok && (~req_empty || src_req_valid);
    assign dest_req       = req_empty ? src_req : req_mem[req_rptr[RQ_AW-1:0]];
    assign req_push       = src_req_fire && !(req_empty && credit_ok && dest_req_ready);
    assign req_pop        = dest_req_fire && !req_empty;

    assign src_resp_valid = ~resp_empty || resp_accept;
    assign src_resp       = resp_empty ? dest_resp : resp_mem[resp_rptr[RS_AW-1:0]];
    assign resp_push      = resp_accept && !(resp_empty && src_resp_ready);
    assign resp_pop       = src_resp_fire && !resp_empty;
`else
    assign dest_req_valid = ~req_empty && credit_ok;
    assign dest_req       = req_mem[req_rptr[RQ_AW-1:0]];
    assign req_push       = src_req_fire;
    assign req_pop        = dest_req_fire;

    assign src_resp_valid = ~resp_empty;
    assign src_resp       = resp_mem[resp_rptr[RS_AW-1:0]];
    assign resp_push      = resp_accept;
    assign resp_pop       = src_resp_fire;
`endif

    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wptr[RQ_AW-1:0]] <= src_req;
        if (resp_push) resp_mem[resp_wptr[RS_AW-1:0]] <= dest_resp;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_wptr  <= '0;
            req_rptr  <= '0;
            resp_wptr <= '0;
            resp_rptr <= '0;
        end else begin
            if (req_push)  req_wptr  <= req_wptr + (RQ_AW + 1)'(1);
            if (req_pop)   req_rptr  <= req_rptr + (RQ_AW + 1)'(1);
            if (resp_push) resp_wptr <= resp_wptr + (RS_AW + 1)'(1);
            if (resp_pop)  resp_rptr <= resp_rptr + (RS_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
            resp_err    <= 1'b0;
        end else begin
            case ({dest_req_fire, src_resp_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (unexpected) resp_err <= 1'b1;
        end
    end
endmodule
